zebra_stripe_analyzer: RTL and testbench

ZEBRA_STRIPE_ANALYZER -- requirements
Module: zebra_stripe_analyzer

---
 rtl/zebra_pkg.sv | 23 ++
 rtl/stream_reg_slice.sv | 29 ++
 rtl/zebra_stripe_analyzer.sv | 150 +++++++++++++++
 tb/tb_zebra_stripe_analyzer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zebra_pkg.sv
// Shared types and default constants for the zebra stripe analyzer.
package zebra_pkg;

    typedef enum logic {
        S_BLACK = 1'b0,
        S_WHITE = 1'b1
    } run_state_t;

    localparam int DEF_IMG_WIDTH       = 640;
    localparam int DEF_IMG_HEIGHT      = 480;
    localparam int DEF_W               = 8;
    localparam int DEF_WHITE_THRESHOLD = 180;
    localparam int DEF_MIN_RUN         = 8;
    localparam int DEF_MIN_STRIPES     = 3;
    localparam int DEF_MIN_ROWS        = 16;
    localparam int ROW_CNT_MAX         = 255;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-deep valid/ready register slice; ready passes through when the slot drains.
module stream_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = out_ready | ~out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/zebra_stripe_analyzer.sv
// Counts white stripes per row and flags frames with enough striped rows.
// Per-row stats outputs are built only with ZEBRA_ROW_STATS_EN defined.
module zebra_stripe_analyzer
    import zebra_pkg::*;
#(
    parameter int             IMG_WIDTH       = DEF_IMG_WIDTH,
    parameter int             IMG_HEIGHT      = DEF_IMG_HEIGHT,
    parameter int             W               = DEF_W,
    parameter logic [W-1:0]   WHITE_THRESHOLD = W'(DEF_WHITE_THRESHOLD),
    parameter int             MIN_RUN         = DEF_MIN_RUN,
    parameter int             MIN_STRIPES     = DEF_MIN_STRIPES,
    parameter int             MIN_ROWS        = DEF_MIN_ROWS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              x_valid,
    output logic                              x_ready,
    input  logic [W-1:0]                      x_data,
    output logic                              y_valid,
    input  logic                              y_ready,
    output logic [W-1:0]                      y_data,
    output logic [7:0]                        row_stripes,
    output logic                              row_stripes_valid,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]   stripe_rows,
    output logic                              zebra_detected,
    output logic                              detection_valid
);

    localparam int XW = cw(IMG_WIDTH);
    localparam int YW = cw(IMG_HEIGHT);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam int LW = cw(MIN_RUN + 1);

    run_state_t    state, cur_state, state_nxt;
    logic [LW-1:0] run_len, cur_len, len_nxt;
    logic [7:0]    row_cnt, cur_cnt, cnt_nxt;
    logic [RW-1:0] cur_rows, rows_nxt;
    logic [XW-1:0] x_pos, x_nxt;
    logic [YW-1:0] y_pos, y_nxt;
    logic          hs, white, stripe, det_nxt;
    logic          row_start, row_end, frame_start, frame_end;

    stream_reg_slice #(.W(W)) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (x_valid),
        .in_ready  (x_ready),
        .in_data   (x_data),
        .out_valid (y_valid),
        .out_ready (y_ready),
        .out_data  (y_data)
    );

    assign hs = x_valid && x_ready;

    // Row/frame starts substitute cleared state so nothing carries across rows or frames.
    always_comb begin
        row_start   = (x_pos == '0);
        row_end     = (x_pos == XW'(IMG_WIDTH - 1));
        frame_start = row_start && (y_pos == '0);
        frame_end   = row_end && (y_pos == YW'(IMG_HEIGHT - 1));
        white       = (x_data >= WHITE_THRESHOLD);
        cur_state   = row_start ? S_BLACK : state;
        cur_len     = row_start ? '0 : run_len;
        cur_cnt     = row_start ? '0 : row_cnt;
        cur_rows    = frame_start ? '0 : stripe_rows;

        state_nxt = cur_state;
        len_nxt   = cur_len;
        stripe    = 1'b0;
        case (cur_state)
            S_BLACK: begin
                if (white) begin
                    state_nxt = S_WHITE;
                    len_nxt   = LW'(1);
                end
            end
            S_WHITE: begin
                if (!white) begin
                    state_nxt = S_BLACK;
                    len_nxt   = '0;
                    stripe    = (int'(cur_len) >= MIN_RUN);
                end else if (int'(cur_len) < MIN_RUN) begin
                    len_nxt = cur_len + LW'(1);
                end
            end
            default: ;
        endcase
        // A run still open at the row's last pixel closes here, that pixel included.
        if (row_end && state_nxt == S_WHITE)
            stripe = (int'(len_nxt) >= MIN_RUN);

        cnt_nxt  = (stripe && cur_cnt != 8'(ROW_CNT_MAX)) ? cur_cnt + 8'd1 : cur_cnt;
        rows_nxt = cur_rows;
        if (row_end && int'(cnt_nxt) >= MIN_STRIPES && cur_rows != RW'(IMG_HEIGHT))
            rows_nxt = cur_rows + RW'(1);
        det_nxt = (int'(rows_nxt) >= MIN_ROWS);

        x_nxt = row_end ? '0 : x_pos + XW'(1);
        y_nxt = y_pos;
        if (row_end)
            y_nxt = frame_end ? '0 : y_pos + YW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_BLACK;
            run_len         <= '0;
            row_cnt         <= '0;
            stripe_rows     <= '0;
            x_pos           <= '0;
            y_pos           <= '0;
            zebra_detected  <= 1'b0;
            detection_valid <= 1'b0;
        end else begin
            detection_valid <= 1'b0;
            if (hs) begin
                state       <= state_nxt;
                run_len     <= len_nxt;
                row_cnt     <= cnt_nxt;
                stripe_rows <= rows_nxt;
                x_pos       <= x_nxt;
                y_pos       <= y_nxt;
                if (frame_end) begin
                    zebra_detected  <= det_nxt;
                    detection_valid <= 1'b1;
                end
            end
        end
    end

`ifdef ZEBRA_ROW_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_stripes       <= '0;
            row_stripes_valid <= 1'b0;
        end else begin
            row_stripes_valid <= 1'b0;
            if (hs && row_end) begin
                row_stripes       <= cnt_nxt;
                row_stripes_valid <= 1'b1;
            end
        end
    end
`else
    assign row_stripes       = '0;
    assign row_stripes_valid = 1'b0;
`endif

endmodule

// File: tb/tb_zebra_stripe_analyzer.sv
// Randomized bench for zebra_stripe_analyzer against a run-list reference model.
module tb_zebra_stripe_analyzer;

    localparam int IW    = 16;
    localparam int IH    = 4;
    localparam int W     = 8;
    localparam int MR    = 2;
    localparam int MS    = 3;
    localparam int MROWS = 2;
    localparam int THR   = 180;
    localparam int RSW   = $clog2(IH + 1);
`ifdef ZEBRA_ROW_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           x_valid, x_ready, y_valid, y_ready;
    logic [W-1:0]   x_data, y_data;
    logic [7:0]     row_stripes;
    logic           row_stripes_valid, zebra_detected, detection_valid;
    logic [RSW-1:0] stripe_rows;

    always #5 clk = ~clk;

    zebra_stripe_analyzer #(
        .IMG_WIDTH   (IW),
        .IMG_HEIGHT  (IH),
        .W           (W),
        .MIN_RUN     (MR),
        .MIN_STRIPES (MS),
        .MIN_ROWS    (MROWS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .x_valid           (x_valid),
        .x_ready           (x_ready),
        .x_data            (x_data),
        .y_valid           (y_valid),
        .y_ready           (y_ready),
        .y_data            (y_data),
        .row_stripes       (row_stripes),
        .row_stripes_valid (row_stripes_valid),
        .stripe_rows       (stripe_rows),
        .zebra_detected    (zebra_detected),
        .detection_valid   (detection_valid)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: split the row into maximal white runs, keep those of length >= MR.
    function automatic int count_stripes(input logic [7:0] r [IW]);
        int n = 0;
        int run = 0;
        for (int i = 0; i < IW; i++) begin
            if (int'(r[i]) >= THR) run++;
            else begin
                if (run >= MR) n++;
                run = 0;
            end
        end
        if (run >= MR) n++;
        return (n > 255) ? 255 : n;
    endfunction

    logic [7:0] rowbuf [IW];
    logic [7:0] q [$];
    int  mx, my, rows_m, det_m, rowval_m, det_pulses;
    bit  exp_row_p, exp_det_p, prev_stall;
    int  log_rows [$];
    int  log_det [$];
    int  log_rs [$];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_y_valid", int'(y_valid), 0);
            chk("rst_y_data", int'(y_data), 0);
            chk("rst_row_stripes", int'(row_stripes), 0);
            chk("rst_row_vld", int'(row_stripes_valid), 0);
            chk("rst_zebra", int'(zebra_detected), 0);
            chk("rst_det_vld", int'(detection_valid), 0);
            chk("rst_stripe_rows", int'(stripe_rows), 0);
            mx = 0; my = 0; rows_m = 0; det_m = 0; rowval_m = 0;
            exp_row_p = 0; exp_det_p = 0; prev_stall = 0;
            q.delete();
        end else begin
            chk("row_vld", int'(row_stripes_valid), STATS ? int'(exp_row_p) : 0);
            chk("row_stripes", int'(row_stripes), STATS ? rowval_m : 0);
            chk("det_vld", int'(detection_valid), int'(exp_det_p));
            chk("zebra", int'(zebra_detected), det_m);
            chk("stripe_rows", int'(stripe_rows), rows_m);
            chk("y_valid", int'(y_valid), int'(q.size() != 0));
            if (prev_stall) chk("y_hold", int'(y_valid), 1);
            if (row_stripes_valid) log_rs.push_back(int'(row_stripes));
            if (detection_valid) begin
                det_pulses++;
                log_rows.push_back(int'(stripe_rows));
                log_det.push_back(int'(zebra_detected));
            end
            if (y_valid && y_ready) begin
                if (q.size() == 0) chk("y_extra", 1, 0);
                else chk("y_data", int'(y_data), int'(q.pop_front()));
            end
            prev_stall = y_valid && !y_ready;
            exp_row_p = 0;
            exp_det_p = 0;
            if (x_valid && x_ready) begin
                q.push_back(x_data);
                rowbuf[mx] = x_data;
                if (mx == 0 && my == 0) rows_m = 0;
                if (mx == IW - 1) begin
                    rowval_m  = count_stripes(rowbuf);
                    exp_row_p = 1;
                    if (rowval_m >= MS && rows_m < IH) rows_m++;
                    if (my == IH - 1) begin
                        det_m     = int'(rows_m >= MROWS);
                        exp_det_p = 1;
                    end
                end
                mx = (mx == IW - 1) ? 0 : mx + 1;
                if (mx == 0) my = (my == IH - 1) ? 0 : my + 1;
            end
        end
    end

    bit         stall_en = 0;
    logic [7:0] frm [IW*IH];
    logic [7:0] frm_a [IW*IH];

    initial begin
        y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            y_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    function automatic logic [7:0] wpx();
        return ($urandom_range(0, 3) == 0) ? 8'(THR) : 8'($urandom_range(THR, 255));
    endfunction

    function automatic logic [7:0] bpx();
        return ($urandom_range(0, 3) == 0) ? 8'(THR - 1) : 8'($urandom_range(0, THR - 1));
    endfunction

    task automatic set_row(input int r, input string pat);
        for (int i = 0; i < IW; i++)
            frm[r*IW + i] = (pat.getc(i) == "W") ? wpx() : bpx();
    endtask

    task automatic rand_row(input int r);
        for (int i = 0; i < IW; i++)
            frm[r*IW + i] = ($urandom_range(0, 1) != 0) ? wpx() : bpx();
    endtask

    task automatic drive_pixel(input logic [7:0] p);
        int tries = 0;
        bit took  = 0;
        if (stall_en && $urandom_range(0, 3) == 0) begin
            x_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        x_valid = 1'b1;
        x_data  = p;
        while (!took && tries < 200) begin
            @(negedge clk);
            took = x_valid && x_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!took) chk("hs_timeout", 0, 1);
        x_valid = 1'b0;
    endtask

    task automatic send_frame(input int abort_at);
        for (int i = 0; i < IW*IH; i++) begin
            if (i == abort_at) begin
                x_valid = 1'b0;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            drive_pixel(frm[i]);
        end
    endtask

    initial begin
        x_valid = 1'b0;
        x_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame A: three directed rows plus one random row -> at least 2 qualifying rows.
        set_row(0, "WWBWWBWWBBBBBBBB");
        set_row(1, "WBWBWBBBBBBBBBBB");
        set_row(2, "WWWBWWBBBBBBBBWW");
        rand_row(3);
        frm_a = frm;
        send_frame(-1);

        // Frame B: only one qualifying row.
        set_row(0, "WWBWWBWWBBBBBBBB");
        set_row(1, "WBWBWBBBBBBBBBBB");
        set_row(2, "BBBBBBBBBBBBBBBB");
        set_row(3, "WBWBWBWBWBWBWBWB");
        send_frame(-1);

        stall_en = 1;
        frm = frm_a;
        send_frame(-1);

        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < IH; r++) rand_row(r);
            if (f == 1) set_row(3, "WWWWWWWWWWWWWWWW");
            send_frame(-1);
        end

        // Reset lands just before pixel (7,2), then a clean frame follows.
        for (int r = 0; r < IH; r++) rand_row(r);
        send_frame(2*IW + 7);
        frm = frm_a;
        send_frame(-1);

        stall_en = 0;
        repeat (10) @(posedge clk);
        #1;

        chk("det_count", det_pulses, 8);
        if (log_rows.size() >= 8) begin
            chk("stall_rows", log_rows[2], log_rows[0]);
            chk("stall_det", log_det[2], log_det[0]);
            chk("post_rst_rows", log_rows[7], log_rows[0]);
            chk("post_rst_det", log_det[7], log_det[0]);
        end
        if (log_rs.size() >= 12) begin
            for (int i = 0; i < 4; i++) chk("stall_row_stripes", log_rs[8 + i], log_rs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
